// File: rtl/hash_writer.sv
`default_nettype none
// hash_writer: captures a completed digest and writes it out one 32-bit word per grant,
// word k at BASE_ADDR+k (wrapping), then pulses hash_write_complete for one cycle.
module hash_writer #(
  parameter int HASH_LENGTH = 8,
  parameter int ADDR_WIDTH  = 3,
  parameter int BASE_ADDR   = 0
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      digest_valid,
  output logic                      digest_ready,
  input  logic [HASH_LENGTH*32-1:0] digest_vector,
  input  logic                      write_grant,
  output logic                      hash_write,
  output logic [ADDR_WIDTH-1:0]     hash_write_address,
  output logic [31:0]               hash_write_data,
  output logic                      hash_write_complete,
  output logic                      busy
);

  localparam int INDEX_WIDTH = $clog2(HASH_LENGTH);
  localparam logic [INDEX_WIDTH-1:0] LAST_INDEX = INDEX_WIDTH'(HASH_LENGTH - 1);
  localparam logic [ADDR_WIDTH-1:0]  BASE       = ADDR_WIDTH'(BASE_ADDR);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] WRITE = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]                state;
  logic [INDEX_WIDTH-1:0]    index;
  logic [INDEX_WIDTH-1:0]    next_index;
  logic [HASH_LENGTH*32-1:0] shadow;
  logic                      armed;
  logic                      accept;

  // armed keeps digest_ready low while reset is held, even though state is already IDLE.
  assign digest_ready = armed && (state == IDLE);
  assign busy         = (state == WRITE) || (state == DONE);
  assign accept       = digest_valid && digest_ready;
  assign next_index   = index + 1'b1;

  always_ff @(posedge clock) begin
    if (reset) begin
      state               <= IDLE;
      index               <= '0;
      shadow              <= '0;
      armed               <= 1'b0;
      hash_write          <= 1'b0;
      hash_write_address  <= '0;
      hash_write_data     <= '0;
      hash_write_complete <= 1'b0;
    end else begin
      armed <= 1'b1;
      case (state)
        IDLE: begin
          if (accept) begin
            state              <= WRITE;
            index              <= '0;
            shadow             <= digest_vector;
            hash_write         <= 1'b1;
            hash_write_address <= BASE;
            hash_write_data    <= digest_vector[31:0];
          end
        end
        WRITE: begin
          // Without a grant every output register simply holds (stall).
          if (write_grant) begin
            if (index == LAST_INDEX) begin
              state               <= DONE;
              hash_write          <= 1'b0;
              hash_write_complete <= 1'b1;
            end else begin
              index              <= next_index;
              hash_write_address <= hash_write_address + 1'b1;
              hash_write_data    <= shadow[{next_index, 5'b00000} +: 32];
            end
          end
        end
        DONE: begin
          hash_write_complete <= 1'b0;
          state               <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
